axi_riscv_resv_table: RTL and testbench

Parametrised LR/SC reservation table for the AXI RISC-V atomics path. Generalises single-reservation-per-ID tracking to NUM_ENTRIES concurrent reservations with configurable granule, round-robin eviction and write snooping. Sits beside the AMO unit on the slave side of the atomics adapter and decides SC success/failure before the write is forwarded downstream.

---
 rtl/axi_riscv_resv_table.sv | 235 +++++++++++++++++++++++
 tb/tb_axi_riscv_resv_table.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_riscv_resv_table.sv
// rtl/axi_riscv_resv_table.sv - LR/SC reservation table with write snooping; optional lifetime via AXI_RISCV_RESV_TIMEOUT_EN
module axi_riscv_resv_table #(
    parameter int unsigned ADDR_WIDTH     = 64,
    parameter int unsigned ID_WIDTH       = 8,
    parameter int unsigned NUM_ENTRIES    = 4,
    parameter int unsigned GRANULE_LSB    = 3,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               lr_valid_i,
    output logic                               lr_ready_o,
    input  logic [ADDR_WIDTH-1:0]              lr_addr_i,
    input  logic [ID_WIDTH-1:0]                lr_id_i,
    input  logic                               sc_valid_i,
    output logic                               sc_ready_o,
    input  logic [ADDR_WIDTH-1:0]              sc_addr_i,
    input  logic [ID_WIDTH-1:0]                sc_id_i,
    output logic                               sc_rsp_valid_o,
    input  logic                               sc_rsp_ready_i,
    output logic                               sc_rsp_success_o,
    output logic [ID_WIDTH-1:0]                sc_rsp_id_o,
    input  logic                               wr_valid_i,
    input  logic [ADDR_WIDTH-1:0]              wr_addr_i,
    output logic [$clog2(NUM_ENTRIES+1)-1:0]   occupancy_o
);
    localparam int unsigned GW = ADDR_WIDTH - GRANULE_LSB;
    localparam int unsigned VW = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
    localparam int unsigned OW = $clog2(NUM_ENTRIES + 1);
    localparam logic [VW-1:0] VICTIM_LAST = VW'(NUM_ENTRIES - 1);

    typedef enum logic {IDLE, RESP} state_e;

    state_e                 state_q, state_d;
    logic [NUM_ENTRIES-1:0] valid_q, valid_d;
    logic [ID_WIDTH-1:0]    id_q   [NUM_ENTRIES];
    logic [ID_WIDTH-1:0]    id_d   [NUM_ENTRIES];
    logic [GW-1:0]          gran_q [NUM_ENTRIES];
    logic [GW-1:0]          gran_d [NUM_ENTRIES];
    logic [VW-1:0]          victim_q, victim_d;
    logic                   rsp_success_q, rsp_success_d;
    logic [ID_WIDTH-1:0]    rsp_id_q, rsp_id_d;
    logic [OW-1:0]          occ_q, occ_d;

    logic [GW-1:0]          lr_gran, sc_gran, wr_gran;
    logic                   lr_fire, sc_fire, sc_hit;
    logic [NUM_ENTRIES-1:0] expired;
    logic [VW-1:0]          lr_slot;
    logic [VW-1:0]          owner_idx, free_idx;
    logic                   owner_hit, free_hit;
    logic                   unused_addr_lsbs;

    assign lr_gran = lr_addr_i[ADDR_WIDTH-1:GRANULE_LSB];
    assign sc_gran = sc_addr_i[ADDR_WIDTH-1:GRANULE_LSB];
    assign wr_gran = wr_addr_i[ADDR_WIDTH-1:GRANULE_LSB];
    assign unused_addr_lsbs = ^{lr_addr_i[GRANULE_LSB-1:0], sc_addr_i[GRANULE_LSB-1:0],
                                wr_addr_i[GRANULE_LSB-1:0]};

`ifdef AXI_RISCV_RESV_TIMEOUT_EN
    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q [NUM_ENTRIES];
    logic [CW-1:0] cnt_d [NUM_ENTRIES];

    // An entry whose lifetime counter has run out is dead before any matching this cycle
    always_comb begin
        expired = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            expired[i] = (cnt_q[i] == '0);
        end
    end

    // Lifetime counters count down freely and reload on every LR write to the slot
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (cnt_q[i] != '0) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
            end
        end
        if (lr_fire) begin
            cnt_d[lr_slot] = CNT_LOAD;
        end
    end

    // Lifetime counter registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    localparam int unsigned UNUSED_TIMEOUT = TIMEOUT_CYCLES;
    assign expired = '0;
`endif

    // Handshake FSM: IDLE accepts SC (priority over LR), RESP holds the verdict until consumed
    always_comb begin
        state_d        = state_q;
        lr_ready_o     = 1'b0;
        sc_ready_o     = 1'b0;
        sc_rsp_valid_o = 1'b0;
        if (!rst_i) begin
            case (state_q)
                IDLE: begin
                    sc_ready_o = 1'b1;
                    lr_ready_o = !sc_valid_i;
                    if (sc_valid_i) begin
                        state_d = RESP;
                    end
                end
                RESP: begin
                    lr_ready_o     = 1'b1;
                    sc_rsp_valid_o = 1'b1;
                    if (sc_rsp_ready_i) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign sc_fire = sc_valid_i && sc_ready_o;
    assign lr_fire = lr_valid_i && lr_ready_o;

    // Table update: expiry and snoop first, then the SC verdict, then the LR placement
    always_comb begin
        valid_d       = valid_q;
        id_d          = id_q;
        gran_d        = gran_q;
        victim_d      = victim_q;
        rsp_success_d = rsp_success_q;
        rsp_id_d      = rsp_id_q;
        sc_hit        = 1'b0;
        owner_hit     = 1'b0;
        owner_idx     = '0;
        free_hit      = 1'b0;
        free_idx      = '0;
        lr_slot       = victim_q;

        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (expired[i] || (wr_valid_i && gran_q[i] == wr_gran)) begin
                valid_d[i] = 1'b0;
            end
        end

        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (valid_d[i] && id_q[i] == sc_id_i && gran_q[i] == sc_gran) begin
                sc_hit = 1'b1;
            end
        end

        if (sc_fire) begin
            rsp_success_d = sc_hit;
            rsp_id_d      = sc_id_i;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (id_q[i] == sc_id_i || (sc_hit && gran_q[i] == sc_gran)) begin
                    valid_d[i] = 1'b0;
                end
            end
        end

        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (valid_d[i] && id_q[i] == lr_id_i) begin
                owner_hit = 1'b1;
                owner_idx = i[VW-1:0];
            end
        end
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!valid_d[i]) begin
                free_hit = 1'b1;
                free_idx = i[VW-1:0];
            end
        end

        if (owner_hit) begin
            lr_slot = owner_idx;
        end else if (free_hit) begin
            lr_slot = free_idx;
        end

        if (lr_fire) begin
            valid_d[lr_slot] = 1'b1;
            id_d[lr_slot]    = lr_id_i;
            gran_d[lr_slot]  = lr_gran;
            if (!owner_hit && !free_hit) begin
                victim_d = (victim_q == VICTIM_LAST) ? '0 : victim_q + 1'b1;
            end
        end
    end

    // Occupancy is the population count of the next-state valid vector
    always_comb begin
        occ_d = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            occ_d = occ_d + OW'(valid_d[i]);
        end
    end

    // Control and verdict registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            valid_q       <= '0;
            victim_q      <= '0;
            rsp_success_q <= 1'b0;
            rsp_id_q      <= '0;
            occ_q         <= '0;
        end else begin
            state_q       <= state_d;
            valid_q       <= valid_d;
            victim_q      <= victim_d;
            rsp_success_q <= rsp_success_d;
            rsp_id_q      <= rsp_id_d;
            occ_q         <= occ_d;
        end
    end

    // Entry payload registers; meaningful only while the matching valid bit is set
    always_ff @(posedge clk_i) begin
        id_q   <= id_d;
        gran_q <= gran_d;
    end

    assign sc_rsp_success_o = rsp_success_q;
    assign sc_rsp_id_o      = rsp_id_q;
    assign occupancy_o      = occ_q;

endmodule

// File: tb/tb_axi_riscv_resv_table.sv
// tb/tb_axi_riscv_resv_table.sv - self-checking bench for axi_riscv_resv_table
module tb_axi_riscv_resv_table;
    localparam int AW  = 64;
    localparam int IW  = 8;
    localparam int N   = 4;
    localparam int GL  = 3;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          lr_valid, lr_ready, sc_valid, sc_ready;
    logic [AW-1:0] lr_addr, sc_addr, wr_addr;
    logic [IW-1:0] lr_id, sc_id, rsp_id;
    logic          rsp_valid, rsp_ready, rsp_success, wr_valid;
    logic [2:0]    occupancy;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    axi_riscv_resv_table #(
        .ADDR_WIDTH(AW), .ID_WIDTH(IW), .NUM_ENTRIES(N),
        .GRANULE_LSB(GL), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .lr_valid_i(lr_valid), .lr_ready_o(lr_ready), .lr_addr_i(lr_addr), .lr_id_i(lr_id),
        .sc_valid_i(sc_valid), .sc_ready_o(sc_ready), .sc_addr_i(sc_addr), .sc_id_i(sc_id),
        .sc_rsp_valid_o(rsp_valid), .sc_rsp_ready_i(rsp_ready),
        .sc_rsp_success_o(rsp_success), .sc_rsp_id_o(rsp_id),
        .wr_valid_i(wr_valid), .wr_addr_i(wr_addr),
        .occupancy_o(occupancy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a set of reservations (owner, granule, birth cycle) plus a round-robin victim
    bit          m_v   [N];
    int          m_id  [N];
    logic [63:0] m_g   [N];
    int          m_born[N];
    int          m_vic = 0;
    bit          m_resp = 0, m_succ = 0;
    int          m_rid = 0, m_occ = 0, cyc = 0;
    bit          m_lr_rdy, m_sc_rdy, m_hit;
    int          m_slot;

    function automatic logic [63:0] gran(input logic [63:0] a);
        return a >> GL;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            for (int i = 0; i < N; i++) m_v[i] = 0;
            m_vic = 0; m_resp = 0; m_succ = 0; m_rid = 0; m_occ = 0;
        end else begin
            m_sc_rdy = !m_resp;
            m_lr_rdy = m_resp || !sc_valid;
`ifdef AXI_RISCV_RESV_TIMEOUT_EN
            for (int i = 0; i < N; i++)
                if (m_v[i] && (cyc - m_born[i]) >= TMO) m_v[i] = 0;
`endif
            if (wr_valid)
                for (int i = 0; i < N; i++)
                    if (m_g[i] == gran(wr_addr)) m_v[i] = 0;
            if (m_resp) begin
                if (rsp_ready) m_resp = 0;
            end else if (sc_valid) begin
                m_hit = 0;
                for (int i = 0; i < N; i++)
                    if (m_v[i] && m_id[i] == int'(sc_id) && m_g[i] == gran(sc_addr)) m_hit = 1;
                for (int i = 0; i < N; i++)
                    if (m_id[i] == int'(sc_id) || (m_hit && m_g[i] == gran(sc_addr))) m_v[i] = 0;
                m_resp = 1; m_succ = m_hit; m_rid = int'(sc_id);
            end
            if (lr_valid && m_lr_rdy) begin
                m_slot = -1;
                for (int i = 0; i < N; i++)
                    if (m_v[i] && m_id[i] == int'(lr_id)) m_slot = i;
                for (int i = 0; i < N && m_slot < 0; i++)
                    if (!m_v[i]) m_slot = i;
                if (m_slot < 0) begin
                    m_slot = m_vic;
                    m_vic  = (m_vic + 1) % N;
                end
                m_v[m_slot] = 1; m_id[m_slot] = int'(lr_id);
                m_g[m_slot] = gran(lr_addr); m_born[m_slot] = cyc;
            end
            m_occ = 0;
            for (int i = 0; i < N; i++) m_occ += int'(m_v[i]);
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("m_lr_ready",  lr_ready,    (!rst && (m_resp || !sc_valid)) ? 1 : 0);
            check("m_sc_ready",  sc_ready,    (!rst && !m_resp) ? 1 : 0);
            check("m_rsp_valid", rsp_valid,   (!rst && m_resp) ? 1 : 0);
            check("m_success",   rsp_success, m_succ);
            check("m_rsp_id",    rsp_id,      m_rid);
            check("m_occupancy", occupancy,   m_occ);
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1; tick(); rst = 0;
    endtask

    task automatic lr(input int id, input logic [63:0] addr);
        lr_valid = 1; lr_id = IW'(id); lr_addr = addr;
        tick();
        lr_valid = 0;
    endtask

    task automatic sc(input int id, input logic [63:0] addr, input bit exp, input string name);
        sc_valid = 1; sc_id = IW'(id); sc_addr = addr; rsp_ready = 0;
        tick();
        sc_valid = 0; wr_valid = 0;
        @(negedge clk);
        check({name, "_valid"},   rsp_valid,   1);
        check({name, "_success"}, rsp_success, exp);
        check({name, "_id"},      rsp_id,      id);
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
    endtask

    task automatic occ_is(input int exp, input string name);
        @(negedge clk);
        check(name, occupancy, exp);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; lr_valid = 0; sc_valid = 0; rsp_ready = 0; wr_valid = 0;
        lr_addr = '0; sc_addr = '0; wr_addr = '0; lr_id = '0; sc_id = '0;
        tick();
        chk_en = 1;
        @(negedge clk);
        check("rst_lr_ready", lr_ready, 0);
        check("rst_sc_ready", sc_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_occ", occupancy, 0);
        tick();
        rst = 0;

        // LR then SC to same granule succeeds
        lr(1, 64'h1000);
        occ_is(1, "tp1_occ_after_lr");
        sc(1, 64'h1004, 1, "tp1");
        occ_is(0, "tp1_occ_after_sc");

        // Snoop between LR and SC kills the reservation
        lr(1, 64'h1000);
        wr_valid = 1; wr_addr = 64'h1000;
        tick();
        wr_valid = 0;
        occ_is(0, "tp2_occ_after_snoop");
        sc(1, 64'h1000, 0, "tp2");

        // Snoop and LR on same granule in one cycle: LR survives
        wr_valid = 1; wr_addr = 64'h7000;
        lr(7, 64'h7000);
        wr_valid = 0;
        occ_is(1, "snoop_lr_occ");
        sc(7, 64'h7000, 1, "snoop_lr");

        // Snoop and SC on same granule in one cycle: SC fails
        lr(8, 64'h8000);
        wr_valid = 1; wr_addr = 64'h8000;
        sc(8, 64'h8000, 0, "snoop_sc");
        occ_is(0, "snoop_sc_occ");

        // Eviction: five owners into four slots, round-robin victim
        for (int i = 1; i <= 5; i++) lr(i, 64'h3000 + 64'(i * 8));
        occ_is(4, "tp3_occ_full");
        sc(1, 64'h3008, 0, "tp3_evicted");
        sc(5, 64'h3028, 1, "tp3_newest");
        occ_is(3, "tp3_occ_after");
        lr(6, 64'h3030);
        lr(7, 64'h3038);
        sc(2, 64'h3010, 0, "tp3_victim1");
        sc(3, 64'h3018, 1, "tp3_survivor");

        // Two owners on one granule: successful SC clears both
        do_reset();
        lr(2, 64'h2000);
        lr(3, 64'h2000);
        occ_is(2, "tp4_occ");
        sc(2, 64'h2000, 1, "tp4_first");
        occ_is(0, "tp4_occ_after");
        sc(3, 64'h2000, 0, "tp4_second");

        // SC and LR together, backpressured verdict, reset while responding
        do_reset();
        lr(1, 64'h5000);
        sc_valid = 1; sc_id = 8'd1; sc_addr = 64'h5000;
        lr_valid = 1; lr_id = 8'd9; lr_addr = 64'h6000;
        @(negedge clk);
        check("tp5_lr_blocked", lr_ready, 0);
        check("tp5_sc_ready", sc_ready, 1);
        tick();
        sc_valid = 0; lr_valid = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("tp5_hold_valid", rsp_valid, 1);
            check("tp5_hold_success", rsp_success, 1);
            check("tp5_hold_id", rsp_id, 1);
            check("tp5_hold_sc_ready", sc_ready, 0);
        end
        tick();
        rst = 1;
        tick();
        @(negedge clk);
        check("tp5_rst_valid", rsp_valid, 0);
        check("tp5_rst_success", rsp_success, 0);
        check("tp5_rst_id", rsp_id, 0);
        check("tp5_rst_lr_ready", lr_ready, 0);
        check("tp5_rst_sc_ready", sc_ready, 0);
        check("tp5_rst_occ", occupancy, 0);
        tick();
        rst = 0;

`ifdef AXI_RISCV_RESV_TIMEOUT_EN
        // Reservation lifetime of eight cycles
        do_reset();
        lr(4, 64'h9000);
        repeat (9) tick();
        sc(4, 64'h9000, 0, "tmo_late");
        lr(4, 64'h9000);
        repeat (4) tick();
        sc(4, 64'h9000, 1, "tmo_early");
`endif

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
